// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose
//   Pipeline hazard controller for a five-stage in-order core. It arbitrates
//   between three kinds of pipeline disturbance and produces the load/flush
//   controls for the PC and the four pipeline registers:
//     * freeze   : an instruction or data memory access is outstanding, so the
//                  whole pipeline holds (highest priority)
//     * flush    : a branch/jump resolved in EX was mispredicted, so IF/ID and
//                  ID/EX are replaced with NOP bubbles
//     * bubble   : load-use hazard; IF/ID and PC hold for one cycle and a NOP
//                  bubble is inserted into ID/EX
//     * normal   : everything advances
//   The load/flush outputs are combinational from the state registers and the
//   current inputs, so the pipeline sees the decision in the same cycle.
//
// Configuration
//   HAZARD_PERF_CNT_EN : when defined, 32-bit wrapping performance counters
//                        count freeze, bubble and flush cycles. When undefined,
//                        no counter flops exist and the counter outputs are 0.
//
// Parameters
//   TIMEOUT : consecutive freeze cycles after which stall_timeout is raised.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   id_rs1, id_rs2            source register indices of the IF/ID instruction
//   id_uses_rs1, id_uses_rs2  IF/ID instruction really reads that source
//   ex_rd, ex_is_load         destination / load flag of the ID/EX instruction
//   ex_br_mispredict          branch resolved in EX disagrees with prediction
//   imem_req, imem_resp       instruction memory request / response
//   dmem_req, dmem_resp       data memory request / response
//   pc_load .. mem_wb_load    load enables for PC and pipeline registers
//   if_id_flush, id_ex_flush  load a NOP bubble instead of the normal value
//   stall_timeout             sticky flag: memory stalled for TIMEOUT cycles
//   fsm_state                 debug view of the FSM (0 = RUN, 1 = FREEZE)
//   freeze_cnt, bubble_cnt,
//   flush_cnt                 performance counters
//
// Handshake note
//   A memory access is considered outstanding while its req is high and its
//   resp is low; the cycle in which resp is seen is already an unfrozen cycle.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_br_mispredict,
  input  logic        imem_req,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  output logic        pc_load,
  output logic        if_id_load,
  output logic        id_ex_load,
  output logic        ex_mem_load,
  output logic        mem_wb_load,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        stall_timeout,
  output logic        fsm_state,
  output logic [31:0] freeze_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
);

  // Wide enough to hold the value TIMEOUT itself (the saturation point).
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  state_t         state;
  logic           flush_pend;
  logic [WW-1:0]  wait_ctr;
  logic [WW-1:0]  wait_next;

  logic mem_busy;
  logic load_use;
  logic pend_eff;
  logic do_freeze;
  logic do_flush;
  logic do_bubble;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign mem_busy = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // While rst is high the outputs must behave as if flush_pend already held
  // its reset value, so mask the register rather than wait for the edge.
  assign pend_eff = flush_pend & ~rst;

  assign do_freeze = mem_busy;
  assign do_flush  = ~mem_busy & (ex_br_mispredict | pend_eff);
  // A flush kills the dependent instruction anyway, so load-use is ignored.
  assign do_bubble = ~mem_busy & ~do_flush & load_use;

  // ---------------------------------------------------------------------------
  // Load / flush outputs: freeze > flush > bubble > normal
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_load     = 1'b1;
    if_id_load  = 1'b1;
    id_ex_load  = 1'b1;
    ex_mem_load = 1'b1;
    mem_wb_load = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (do_freeze) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
    end else if (do_flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (do_bubble) begin
      // Hold the dependent instruction in IF/ID for one cycle while the load
      // moves on to MEM; ID/EX receives a NOP. The next cycle the load is in
      // EX/MEM, so load_use drops by itself and the stall lasts one cycle.
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall watchdog: counts the cycles the pipeline is held by memory, which
  // includes the first busy cycle seen while the FSM is still in RUN. Clears
  // as soon as memory is no longer busy and saturates at TIMEOUT.
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_next = '0;
    if (mem_busy) begin
      if (wait_ctr == TIMEOUT_W) begin
        wait_next = wait_ctr;
      end else begin
        wait_next = wait_ctr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      flush_pend    <= 1'b0;
      wait_ctr      <= '0;
      stall_timeout <= 1'b0;
    end else begin
      case (state)
        RUN:    if (mem_busy)  state <= FREEZE;
        FREEZE: if (!mem_busy) state <= RUN;
      endcase

      // A mispredict seen while frozen is remembered until the first unfrozen
      // cycle. In an unfrozen cycle any pending flush is applied, so the
      // register always clears there; this keeps it from firing twice.
      flush_pend <= mem_busy & (flush_pend | ex_br_mispredict);

      wait_ctr <= wait_next;
      if (wait_next == TIMEOUT_W) begin
        stall_timeout <= 1'b1;
      end
    end
  end

  assign fsm_state = (state == FREEZE);

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] freeze_q;
  logic [31:0] bubble_q;
  logic [31:0] flush_q;

  // Natural 32-bit wrap-around on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      freeze_q <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (do_freeze) freeze_q <= freeze_q + 32'd1;
      if (do_bubble) bubble_q <= bubble_q + 32'd1;
      if (do_flush)  flush_q  <= flush_q + 32'd1;
    end
  end

  assign freeze_cnt = freeze_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`else
  assign freeze_cnt = 32'd0;
  assign bubble_cnt = 32'd0;
  assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl (TIMEOUT = 8). Inputs are driven 1 ns after
// the rising edge, outputs are sampled 1 ns later, well away from the edge.
// The seven load/flush outputs are packed as
//   {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}.
// Counter expectations depend on whether HAZARD_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int TIMEOUT = 8;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] C_NORMAL = 7'b11111_00;
  localparam logic [6:0] C_FREEZE = 7'b00000_00;
  localparam logic [6:0] C_FLUSH  = 7'b11111_11;
  localparam logic [6:0] C_BUBBLE = 7'b00111_01;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_mispredict;
  logic        imem_req, imem_resp, dmem_req, dmem_resp;
  logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic        if_id_flush, id_ex_flush, stall_timeout, fsm_state;
  logic [31:0] freeze_cnt, bubble_cnt, flush_cnt;
  logic [6:0]  ctl;

  assign ctl = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                if_id_flush, id_ex_flush};

  hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_rd            (ex_rd),
    .ex_is_load       (ex_is_load),
    .ex_br_mispredict (ex_br_mispredict),
    .imem_req         (imem_req),
    .imem_resp        (imem_resp),
    .dmem_req         (dmem_req),
    .dmem_resp        (dmem_resp),
    .pc_load          (pc_load),
    .if_id_load       (if_id_load),
    .id_ex_load       (id_ex_load),
    .ex_mem_load      (ex_mem_load),
    .mem_wb_load      (mem_wb_load),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .stall_timeout    (stall_timeout),
    .fsm_state        (fsm_state),
    .freeze_cnt       (freeze_cnt),
    .bubble_cnt       (bubble_cnt),
    .flush_cnt        (flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_br_mispredict = 1'b0;
    imem_req = 1'b0; imem_resp = 1'b0;
    dmem_req = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic load_use_rs1(input logic [4:0] rd, input logic [4:0] rs);
    ex_is_load = 1'b1; ex_rd = rd; id_uses_rs1 = 1'b1; id_rs1 = rs;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle();
    #2;

    // During reset the outputs already follow the priority rules.
    chk("rst_normal_ctl", 32'(ctl), 32'(C_NORMAL));
    ex_br_mispredict = 1'b1; settle();
    chk("rst_flush_ctl", 32'(ctl), 32'(C_FLUSH));
    ex_br_mispredict = 1'b0; dmem_req = 1'b1; settle();
    chk("rst_freeze_ctl", 32'(ctl), 32'(C_FREEZE));
    idle();
    tick(); tick();
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_timeout", 32'(stall_timeout), 32'd0);
    chk("rst_freeze_cnt", freeze_cnt, 32'd0);
    chk("rst_bubble_cnt", bubble_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    rst = 1'b0;
    settle();
    chk("idle_normal", 32'(ctl), 32'(C_NORMAL));

    // Load-use through rs1: exactly one bubble cycle.
    tick();
    load_use_rs1(5'd5, 5'd5); settle();
    chk("lu_rs1_bubble", 32'(ctl), 32'(C_BUBBLE));
    tick();
    idle(); settle();
    chk("lu_rs1_after", 32'(ctl), 32'(C_NORMAL));
    chk("lu_rs1_bubble_cnt", bubble_cnt, pexp(1));

    // Load-use through rs2, and the same indices with rs2 unused.
    ex_is_load = 1'b1; ex_rd = 5'd7; id_uses_rs2 = 1'b1; id_rs2 = 5'd7; settle();
    chk("lu_rs2_bubble", 32'(ctl), 32'(C_BUBBLE));
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_uses_rs2 = 1'b0; id_rs2 = 5'd7; settle();
    chk("lu_rs2_unused", 32'(ctl), 32'(C_NORMAL));
    chk("lu_rs2_bubble_cnt", bubble_cnt, pexp(2));

    // x0 never stalls; a non-load producer never stalls.
    idle(); load_use_rs1(5'd0, 5'd0); settle();
    chk("x0_normal", 32'(ctl), 32'(C_NORMAL));
    tick();
    idle(); load_use_rs1(5'd5, 5'd5); ex_is_load = 1'b0; settle();
    chk("nonload_normal", 32'(ctl), 32'(C_NORMAL));
    tick();
    idle(); settle();
    chk("x0_bubble_cnt", bubble_cnt, pexp(2));

    // Data memory stall for three cycles.
    dmem_req = 1'b1; dmem_resp = 1'b0; settle();
    chk("dfrz_c1_ctl", 32'(ctl), 32'(C_FREEZE));
    chk("dfrz_c1_state", 32'(fsm_state), 32'd0);
    tick();
    chk("dfrz_c2_ctl", 32'(ctl), 32'(C_FREEZE));
    chk("dfrz_c2_state", 32'(fsm_state), 32'd1);
    tick();
    chk("dfrz_c3_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    dmem_resp = 1'b1; settle();
    chk("dfrz_resp_ctl", 32'(ctl), 32'(C_NORMAL));
    chk("dfrz_resp_state", 32'(fsm_state), 32'd1);
    tick();
    idle(); settle();
    chk("dfrz_run_state", 32'(fsm_state), 32'd0);
    chk("dfrz_freeze_cnt", freeze_cnt, pexp(3));

    // Instruction memory stall of four cycles with a mispredict in cycle 2.
    imem_req = 1'b1; imem_resp = 1'b0; settle();
    chk("mpf_c1_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    ex_br_mispredict = 1'b1; settle();
    chk("mpf_c2_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    ex_br_mispredict = 1'b0; settle();
    chk("mpf_c3_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    chk("mpf_c4_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    imem_resp = 1'b1; settle();
    chk("mpf_c5_flush", 32'(ctl), 32'(C_FLUSH));
    tick();
    idle(); settle();
    chk("mpf_c6_normal", 32'(ctl), 32'(C_NORMAL));
    chk("mpf_flush_cnt", flush_cnt, pexp(1));
    chk("mpf_freeze_cnt", freeze_cnt, pexp(7));

    // Mispredict and load-use together: flush wins, no bubble counted.
    ex_br_mispredict = 1'b1; load_use_rs1(5'd9, 5'd9); settle();
    chk("mp_lu_ctl", 32'(ctl), 32'(C_FLUSH));
    tick();
    idle(); settle();
    chk("mp_lu_bubble_cnt", bubble_cnt, pexp(2));
    chk("mp_lu_flush_cnt", flush_cnt, pexp(2));

    // Reset during a freeze discards the pending flush.
    dmem_req = 1'b1; ex_br_mispredict = 1'b1; settle();
    chk("rstfrz_c1_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    ex_br_mispredict = 1'b0; rst = 1'b1; settle();
    chk("rstfrz_c2_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    rst = 1'b0; idle(); settle();
    chk("rstfrz_no_flush", 32'(ctl), 32'(C_NORMAL));
    chk("rstfrz_flush_cnt", flush_cnt, 32'd0);
    tick();
    chk("rstfrz_still_normal", 32'(ctl), 32'(C_NORMAL));

    // Watchdog: ten stalled cycles, flag visible from cycle 9 onward.
    for (int k = 1; k <= 10; k++) begin
      dmem_req = 1'b1; dmem_resp = 1'b0; settle();
      chk($sformatf("tmo_c%0d", k), 32'(stall_timeout), (k > TIMEOUT) ? 32'd1 : 32'd0);
      tick();
    end
    idle(); settle();
    chk("tmo_after_stall", 32'(stall_timeout), 32'd1);
    chk("tmo_freeze_cnt", freeze_cnt, pexp(10));
    tick(); tick();
    chk("tmo_sticky", 32'(stall_timeout), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; settle();
    chk("tmo_rst_clear", 32'(stall_timeout), 32'd0);
    chk("tmo_rst_freeze_cnt", freeze_cnt, 32'd0);
    chk("tmo_rst_bubble_cnt", bubble_cnt, 32'd0);
    chk("tmo_rst_flush_cnt", flush_cnt, 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024: number of consecutive FREEZE cycles after which the block flags a memory timeout.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source register indices of the instruction held in IF/ID.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  the IF/ID instruction actually reads the corresponding source.
REQ-006 ex_rd  in  5  destination register index of the instruction held in ID/EX.
REQ-007 ex_is_load  in  1  the ID/EX instruction is a load.
REQ-008 ex_br_mispredict  in  1  the branch or jump resolved in EX disagrees with its prediction.
REQ-009 imem_req, imem_resp, dmem_req, dmem_resp  in  1 each  instruction and data memory request/response.
REQ-010 pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  load enables for the PC and the pipeline registers.
REQ-011 if_id_flush, id_ex_flush  out  1 each  replace the loaded value with a NOP bubble (all-zero control word).
REQ-012 stall_timeout  out  1  sticky memory-timeout flag.
REQ-013 freeze_cnt, bubble_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-014 mem_busy SHALL equal (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp).
REQ-015 load_use SHALL equal ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-016 The FSM SHALL have two states, RUN and FREEZE. RUN->FREEZE when mem_busy. FREEZE->RUN on the first cycle mem_busy=0.
REQ-017 Output priority SHALL be: freeze > flush > load-use bubble > normal. All outputs SHALL be combinational from state, flush_pend and inputs.
REQ-018 Freeze (mem_busy=1, either state): all five loads SHALL be 0 and both flushes SHALL be 0.
REQ-019 Flush (mem_busy=0 and (ex_br_mispredict | flush_pend)): all loads SHALL be 1 and if_id_flush=id_ex_flush=1. load_use SHALL be ignored in that cycle.
REQ-020 Bubble (load_use, no freeze, no flush): pc_load=if_id_load=0; id_ex_load=1 with id_ex_flush=1; ex_mem_load=mem_wb_load=1. The stall SHALL last exactly one cycle per load-use pair.
REQ-021 Normal: all loads SHALL be 1 and all flushes SHALL be 0.
REQ-022 flush_pend register: set when ex_br_mispredict & mem_busy. Cleared in the cycle a flush is applied. A mispredict arriving during FREEZE SHALL be flushed on the first unfrozen cycle, never lost or applied twice.
REQ-023 wait_ctr register: increments each FREEZE cycle, cleared in RUN, saturates at TIMEOUT. stall_timeout SHALL set when wait_ctr reaches TIMEOUT and hold until rst.
REQ-024 ex_rd=0 SHALL never cause a bubble.

Reset
REQ-025 On rst: state=RUN, flush_pend=0, wait_ctr=0, stall_timeout=0, all counters=0.
REQ-026 Loads and flushes SHALL follow REQ-017..021 during rst, with state and flush_pend taken as their reset values.
REQ-027 rst asserted mid-FREEZE SHALL discard any pending flush.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: counters are 32-bit, wrap at 2^32, and increment as follows:
- freeze_cnt: each freeze cycle.
- bubble_cnt: each bubble cycle.
- flush_cnt: each flush cycle.
REQ-029 Macro HAZARD_PERF_CNT_EN undefined: no counter flops are instantiated and freeze_cnt, bubble_cnt, flush_cnt SHALL be tied to 0.

Verification
REQ-030 Load-use: ex_is_load=1, ex_rd=5, id_uses_rs1=1, id_rs1=5 for one cycle -> pc_load=0, if_id_load=0, id_ex_flush=1 for exactly that cycle; bubble_cnt=1.
REQ-031 x0 case: ex_is_load=1, ex_rd=0, id_rs1=0, id_uses_rs1=1 -> normal outputs, no bubble.
REQ-032 Freeze: dmem_req=1, dmem_resp=0 for 3 cycles, then dmem_resp=1 -> all loads=0 for 3 cycles, then 1; freeze_cnt=3.
REQ-033 Mispredict during freeze: imem stalled 4 cycles, ex_br_mispredict pulses in cycle 2 -> no flush during freeze; if_id_flush=id_ex_flush=1 in exactly cycle 5; flush_cnt=1.
REQ-034 Mispredict plus load-use in the same unfrozen cycle -> flush outputs only; pc_load=1; bubble_cnt unchanged.
REQ-035 Timeout (TIMEOUT=8): dmem stalled 10 cycles -> stall_timeout rises after the 8th freeze cycle and stays 1 until rst; rst clears it and all counters.
